// File: rtl/lbuf_fifo_ctl_if.sv
// Producer/consumer handshake bundle for the line-buffer FIFO controller.
// master: the side issuing push/pop requests; slave: the FIFO controller.
interface lbuf_fifo_ctl_if #(
  parameter int DW = 16
);
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_ack, rd_ack, rd_data, rd_valid
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_ack, rd_ack, rd_data, rd_valid
  );
endinterface

// File: rtl/lbuf_fifo_ctl.sv
// FIFO controller in front of a 2^AW x DW single-port synchronous RAM.
// One RAM access per cycle; contending push/pop alternate round-robin.
//
// Arbitration history (last_op):
//   last_op | meaning
//   --------+--------------------------------------------------
//   0       | last granted access was a read; contention -> write
//   1       | last granted access was a write (reset); contention -> read
module lbuf_fifo_ctl #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int AF_LEVEL = 480
) (
  input  logic          sys_clk,
  input  logic          reset,
  lbuf_fifo_ctl_if.slave fifo,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          ram_cen,
  output logic          ram_rw,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(1) << AW;
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          last_op_q, last_op_d;
  logic          rd_valid_q, rd_valid_d;

  logic          w_ok;
  logic          r_ok;
  gnt_e          gnt;

  // Status flags come only from the registered occupancy, never from this cycle's grant.
  always_comb begin
    count       = count_q;
    full        = (count_q == DEPTH_C);
    empty       = (count_q == '0);
    almost_full = (count_q >= AF_C);
  end

  // Pointer, occupancy, arbitration history and read-valid registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_op_q  <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_op_q  <= last_op_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Arbitrate the single RAM port and compute the next register values.
  always_comb begin
    w_ok       = fifo.wr_req & ~full;
    r_ok       = fifo.rd_req & ~empty;
    gnt        = GNT_IDLE;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_op_d  = last_op_q;
    rd_valid_d = 1'b0;

    if (!reset) begin
      if (w_ok && r_ok) begin
        gnt = last_op_q ? GNT_RD : GNT_WR;
      end else if (w_ok) begin
        gnt = GNT_WR;
      end else if (r_ok) begin
        gnt = GNT_RD;
      end
    end

    case (gnt)
      GNT_WR: begin
        wr_ptr_d  = wr_ptr_q + AW'(1);
        count_d   = count_q + (AW+1)'(1);
        last_op_d = 1'b1;
      end
      GNT_RD: begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        count_d    = count_q - (AW+1)'(1);
        last_op_d  = 1'b0;
        rd_valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Drive the RAM port and handshakes from the current grant; read data passes straight through.
  always_comb begin
    ram_cen       = 1'b1;
    ram_rw        = 1'b1;
    ram_a         = rd_ptr_q;
    ram_din       = fifo.wr_data;
    fifo.wr_ack   = 1'b0;
    fifo.rd_ack   = 1'b0;
    fifo.rd_valid = rd_valid_q;
    fifo.rd_data  = ram_dout;

    case (gnt)
      GNT_WR: begin
        ram_cen     = 1'b0;
        ram_rw      = 1'b0;
        ram_a       = wr_ptr_q;
        fifo.wr_ack = 1'b1;
      end
      GNT_RD: begin
        ram_cen     = 1'b0;
        ram_rw      = 1'b1;
        ram_a       = rd_ptr_q;
        fifo.rd_ack = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/lbuf_fifo_ctl.md
Name: lbuf_fifo_ctl

Overview:
- FIFO controller that sits directly upstream of the 512x16 synchronous single-port line-buffer RAM.
- Drives the RAM's active-low cen, rw (1 = read, 0 = write), 9-bit address and write data.
- Consumes the RAM's registered read data.
- Presents a push/pop FIFO interface to the producer and consumer. Only one RAM access occurs per cycle, so simultaneous push and pop requests are arbitrated.

Parameters:
- AW, 9, RAM address width; FIFO depth is 2^AW.
- DW, 16, data width.
- AF_LEVEL, 480, almost_full asserts when count >= AF_LEVEL.

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  producer requests a push.
- wr_data  in  [0:DW-1]  push data.
- wr_ack  out  1  combinational; push accepted this cycle.
- rd_req  in  1  consumer requests a pop.
- rd_ack  out  1  combinational; pop issued to the RAM this cycle.
- rd_data  out  [0:DW-1]  pop data, valid while rd_valid is high.
- rd_valid  out  1  registered; high exactly one cycle after rd_ack.
- count  out  [0:AW]  current occupancy, 0 to 2^AW.
- full  out  1  count == 2^AW.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- ram_cen  out  1  to RAM cen; active low.
- ram_rw  out  1  to RAM rw.
- ram_a  out  [0:AW-1]  to RAM address.
- ram_din  out  [0:DW-1]  to RAM z_in.
- ram_dout  in  [0:DW-1]  from RAM z_out.

Behaviour:
- Clocking and reset: one clock (sys_clk). Reset is synchronous, active-high.
- State: wr_ptr[AW], rd_ptr[AW], count[AW+1], last_op (0 = read, 1 = write), rd_valid.
- Reset values: wr_ptr = rd_ptr = 0, count = 0, last_op = 1, rd_valid = 0.
  - While reset is high: wr_ack = rd_ack = 0, ram_cen = 1, ram_rw = 1.
  - Derived outputs after reset: empty = 1, full = 0, almost_full = 0, count = 0.
- Eligibility:
  - w_ok = wr_req & ~full.
  - r_ok = rd_req & ~empty.
- Grant, combinational:
  - Only w_ok: write.
  - Only r_ok: read.
  - Both: grant the operation opposite to last_op (round-robin). The first contention after reset goes to read.
  - Neither: idle.
- Write grant: ram_cen = 0, ram_rw = 0, ram_a = wr_ptr, ram_din = wr_data, wr_ack = 1. At the clock edge: wr_ptr += 1 (mod 2^AW), count += 1, last_op = 1.
- Read grant: ram_cen = 0, ram_rw = 1, ram_a = rd_ptr, rd_ack = 1. At the clock edge: rd_ptr += 1 (mod 2^AW), count -= 1, last_op = 0, rd_valid <= 1.
- Idle: ram_cen = 1, ram_rw = 1, ram_a = rd_ptr, ram_din = wr_data. last_op is unchanged; rd_valid <= 0.
- Read latency:
  - The RAM registers its output on the edge ending the rd_ack cycle.
  - In the following cycle rd_valid = 1 and rd_data = ram_dout (pass-through, no extra register).
  - The consumer must capture the data during that cycle. The word is not held past the rd_valid pulse.
- Back-to-back reads: rd_valid stays high on consecutive cycles, with a new word each cycle.
- Write-to-read turnaround:
  - A word written at edge N is readable by a read granted in cycle N+1.
  - No bypass is needed. Empty/full are decided from registered count only.
- Full: a push is refused (wr_ack = 0) while full, even if a pop is granted the same cycle. The space frees the next cycle.
- Empty: a pop is refused while empty, even if a push is granted the same cycle.
- Pointer wrap: 511 + 1 -> 0. count uses AW+1 bits so 512 is representable.
- Reset mid-operation: a read granted in the cycle before reset still produces rd_valid = 1 in the reset cycle (registered). Pointers and count clear at the reset edge. No RAM access is issued while reset is high.
- No overflow or underflow: count never exceeds 2^AW and never goes below 0.

Test Plan:
- Reset, then push 0x1234, 0xABCD on consecutive cycles, then pop twice -> wr_ack high both cycles; count 1 then 2; rd_valid in the cycles after each rd_ack with rd_data 0x1234, then 0xABCD; empty = 1 at the end.
- Push 512 words with value = index -> full = 1 and count = 512; almost_full rises when count reaches 480; a 513th push gets wr_ack = 0 and ram_cen = 1.
- From full, hold wr_req and rd_req high together -> read granted first (wr_ack = 0 because full). Next cycle write granted, then reads and writes alternate. count oscillates 511/512; popped data is 0, 1, 2, ... in order.
- From count 2, hold wr_req and rd_req high for 8 cycles -> strict alternation of grants; never two consecutive grants of the same type; count stays within {1, 2, 3}.
- Wrap test: push and pop 700 words in a streaming pattern -> ram_a for writes wraps 511 -> 0; all 700 words read back in order with no loss.
- Assert reset in the cycle after a read grant -> rd_valid = 1 in the reset cycle; afterwards count = 0, empty = 1, and the next push lands at ram_a = 0.
